// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, write-side FSM states, bit-reversal helper.
// Used by both the FFT datapath and the reorder buffer.
package fft_pkg;

   localparam int unsigned W           = 24;
   localparam int unsigned LOG2N       = 4;
   localparam int unsigned N           = 1 << LOG2N;

   // bitrev() works on up to BITREV_MAXW index bits; BITREV_IW indexes into that.
   localparam int unsigned BITREV_MAXW = 16;
   localparam int unsigned BITREV_IW   = 4;

   typedef enum logic {
      WR_IDLE = 1'b0,   // after reset, waiting for the first in_sof
      WR_FILL = 1'b1    // locked to a frame, accepting samples
   } wr_state_e;

   // Reverse the low nbits of x; bits at and above nbits come back as zero.
   function automatic logic [BITREV_MAXW-1:0] bitrev(input logic [BITREV_MAXW-1:0] x,
                                                     input int unsigned           nbits);
      logic [BITREV_MAXW-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < BITREV_MAXW; i++) begin
         if (i < nbits) begin
            r[BITREV_IW'(i)] = x[BITREV_IW'(nbits - 1 - i)];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/reorder_bank.sv
// One frame of sample storage: 2**AW x W register file.
// Ports: clk; we/waddr/wdata synchronous write port; raddr/rdata_c combinational read port.
// Contents are deliberately not reset.
module reorder_bank #(
   parameter int unsigned W  = 24,
   parameter int unsigned AW = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata_c
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];

   // Write-port update.
   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/fft_reorder_buffer.sv
// Converts bit-reversed FFT output frames to natural bin order using two
// ping-pong banks. Samples are written at bitrev(wcnt); a full bank is read
// out linearly over N consecutive cycles starting on the edge after it fills.
// Ports:
//   clk, reset (synchronous, active-low)
//   in_valid/in_sof/in_data   : bit-reversed input stream, in_sof marks sample 0
//   out_valid/out_sof/out_last: registered output qualifiers (bin 0 / bin N-1)
//   out_idx/out_data          : registered natural-order bin index and sample
module fft_reorder_buffer #(
   parameter int unsigned W     = fft_pkg::W,
   parameter int unsigned LOG2N = fft_pkg::LOG2N
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_sof,
   input  logic [W-1:0]     in_data,
   output logic             out_valid,
   output logic             out_sof,
   output logic             out_last,
   output logic [LOG2N-1:0] out_idx,
   output logic [W-1:0]     out_data
);

   localparam int unsigned      N        = 1 << LOG2N;
   localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

   // Write side
   fft_pkg::wr_state_e wr_state_q, wr_state_d;
   logic [LOG2N-1:0]   wcnt_q, wcnt_d;
   logic               wbank_q, wbank_d;
   logic [1:0]         full_q, full_d;

   // Read side
   logic               rd_active_q, rd_active_d;
   logic               rd_bank_q, rd_bank_d;
   logic [LOG2N-1:0]   rd_cnt_q, rd_cnt_d;
   logic               nxt_rd_q, nxt_rd_d;

   // Output registers
   logic               out_valid_q, out_valid_d;
   logic               out_sof_q, out_sof_d;
   logic               out_last_q, out_last_d;
   logic [LOG2N-1:0]   out_idx_q, out_idx_d;
   logic [W-1:0]       out_data_q, out_data_d;

   // Combinational helpers
   logic               accept_c;
   logic [LOG2N-1:0]   wr_pos_c;
   logic [LOG2N-1:0]   wr_addr_c;
   logic               wr_en0_c, wr_en1_c;
   logic               rd_go_c;
   logic               rd_sel_c;
   logic [LOG2N-1:0]   rd_addr_c;
   logic [W-1:0]       rd_data_c;
   logic [W-1:0]       bank0_rdata_c, bank1_rdata_c;

   // Write-side address generation; in_sof forces the sample to position 0.
   always_comb begin
      accept_c  = in_valid && ((wr_state_q == fft_pkg::WR_FILL) || in_sof);
      wr_pos_c  = in_sof ? '0 : wcnt_q;
      wr_addr_c = LOG2N'(fft_pkg::bitrev(fft_pkg::BITREV_MAXW'(wr_pos_c), LOG2N));
      wr_en0_c  = reset && accept_c && !wbank_q;
      wr_en1_c  = reset && accept_c &&  wbank_q;
   end

   // Read-side port selection; an idle reader peeks at the next bank so bin 0
   // is emitted on the very edge that starts the read.
   always_comb begin
      rd_go_c   = rd_active_q || full_q[nxt_rd_q];
      rd_sel_c  = rd_active_q ? rd_bank_q : nxt_rd_q;
      rd_addr_c = rd_active_q ? rd_cnt_q : '0;
      rd_data_c = rd_sel_c ? bank1_rdata_c : bank0_rdata_c;
   end

   // Next-state logic for write FSM, bank flags, reader and output registers.
   always_comb begin
      wr_state_d  = wr_state_q;
      wcnt_d      = wcnt_q;
      wbank_d     = wbank_q;
      full_d      = full_q;
      rd_active_d = rd_active_q;
      rd_bank_d   = rd_bank_q;
      rd_cnt_d    = rd_cnt_q;
      nxt_rd_d    = nxt_rd_q;
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;
      out_last_d  = 1'b0;
      out_idx_d   = out_idx_q;
      out_data_d  = out_data_q;

      // Reader: emit one bin per cycle, releasing the bank after bin N-1.
      if (rd_go_c) begin
         out_valid_d = 1'b1;
         out_sof_d   = (rd_addr_c == '0);
         out_last_d  = (rd_addr_c == LAST_IDX);
         out_idx_d   = rd_addr_c;
         out_data_d  = rd_data_c;
      end
      if (rd_active_q) begin
         if (rd_cnt_q == LAST_IDX) begin
            rd_active_d         = 1'b0;
            full_d[rd_bank_q]   = 1'b0;
         end else begin
            rd_cnt_d = rd_cnt_q + LOG2N'(1);
         end
      end else if (full_q[nxt_rd_q]) begin
         rd_active_d = 1'b1;
         rd_bank_d   = nxt_rd_q;
         rd_cnt_d    = LOG2N'(1);
         nxt_rd_d    = ~nxt_rd_q;
      end

      // Writer: lock on first in_sof, hand the bank over after sample N-1.
      case (wr_state_q)
         fft_pkg::WR_IDLE: begin
            if (accept_c) begin
               wr_state_d = fft_pkg::WR_FILL;
            end
         end
         fft_pkg::WR_FILL: begin
            wr_state_d = fft_pkg::WR_FILL;
         end
         default: begin
            wr_state_d = fft_pkg::WR_IDLE;
         end
      endcase
      if (accept_c) begin
         if (wr_pos_c == LAST_IDX) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
            wcnt_d          = '0;
         end else begin
            wcnt_d = wr_pos_c + LOG2N'(1);
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_state_q  <= fft_pkg::WR_IDLE;
         wcnt_q      <= '0;
         wbank_q     <= 1'b0;
         full_q      <= '0;
         rd_active_q <= 1'b0;
         rd_bank_q   <= 1'b0;
         rd_cnt_q    <= '0;
         nxt_rd_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_last_q  <= 1'b0;
         out_idx_q   <= '0;
         out_data_q  <= '0;
      end else begin
         wr_state_q  <= wr_state_d;
         wcnt_q      <= wcnt_d;
         wbank_q     <= wbank_d;
         full_q      <= full_d;
         rd_active_q <= rd_active_d;
         rd_bank_q   <= rd_bank_d;
         rd_cnt_q    <= rd_cnt_d;
         nxt_rd_q    <= nxt_rd_d;
         out_valid_q <= out_valid_d;
         out_sof_q   <= out_sof_d;
         out_last_q  <= out_last_d;
         out_idx_q   <= out_idx_d;
         out_data_q  <= out_data_d;
      end
   end

   reorder_bank #(
      .W  (W),
      .AW (LOG2N)
   ) u_bank0 (
      .clk     (clk),
      .we      (wr_en0_c),
      .waddr   (wr_addr_c),
      .wdata   (in_data),
      .raddr   (rd_addr_c),
      .rdata_c (bank0_rdata_c)
   );

   reorder_bank #(
      .W  (W),
      .AW (LOG2N)
   ) u_bank1 (
      .clk     (clk),
      .we      (wr_en1_c),
      .waddr   (wr_addr_c),
      .wdata   (in_data),
      .raddr   (rd_addr_c),
      .rdata_c (bank1_rdata_c)
   );

   assign out_valid = out_valid_q;
   assign out_sof   = out_sof_q;
   assign out_last  = out_last_q;
   assign out_idx   = out_idx_q;
   assign out_data  = out_data_q;

endmodule
